// File: rtl/pe_pkg.sv
// Shared types and default widths for the pe_seq_ctrl sequencer slice.
package pe_pkg;

    localparam int ADDR_W = 16;
    localparam int ITER_W = 8;
    localparam int RES_W  = 32;

    // Bit positions inside the PE control bus
    localparam int CTL_FIRST = 0;
    localparam int CTL_LAST  = 1;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        RUN,
        DRAIN,
        DONE
    } state_e;

endpackage

// File: rtl/pe_seq_ctrl_if.sv
// Bus bundle between the sequencer and its instruction memory, SRAMs, PE
// and result buffer. Build option PE_SEQ_STALL_EN adds the stall input.
interface pe_seq_ctrl_if #(
    parameter int ADDR_W  = 16,
    parameter int INST_AW = 2,
    parameter int ITER_W  = 8,
    parameter int RES_W   = 32
);
    logic               start;
    logic [INST_AW:0]   cfg_num_inst;
    logic [ADDR_W-1:0]  cfg_neuron_base;
    logic [ADDR_W-1:0]  cfg_weight_base;
    logic               busy;
    logic               done;
    logic [INST_AW-1:0] inst_addr;
    logic [ITER_W-1:0]  inst_data;
    logic               mem_rd_en;
    logic [ADDR_W-1:0]  neuron_addr;
    logic [ADDR_W-1:0]  weight_addr;
    logic               pe_vld;
    logic [1:0]         pe_ctl;
    logic               pe_res_vld;
    logic [RES_W-1:0]   pe_result;
    logic               res_wr_en;
    logic [INST_AW-1:0] res_wr_addr;
    logic [RES_W-1:0]   res_wr_data;
`ifdef PE_SEQ_STALL_EN
    logic               stall;
`endif

    // Sequencer side
    modport master (
`ifdef PE_SEQ_STALL_EN
        input  stall,
`endif
        input  start, cfg_num_inst, cfg_neuron_base, cfg_weight_base,
        input  inst_data, pe_res_vld, pe_result,
        output busy, done, inst_addr, mem_rd_en, neuron_addr, weight_addr,
        output pe_vld, pe_ctl, res_wr_en, res_wr_addr, res_wr_data
    );

    // Environment side (memories, PE, host)
    modport slave (
`ifdef PE_SEQ_STALL_EN
        output stall,
`endif
        output start, cfg_num_inst, cfg_neuron_base, cfg_weight_base,
        output inst_data, pe_res_vld, pe_result,
        input  busy, done, inst_addr, mem_rd_en, neuron_addr, weight_addr,
        input  pe_vld, pe_ctl, res_wr_en, res_wr_addr, res_wr_data
    );

endinterface

// File: rtl/pe_addr_gen.sv
// Neuron/weight read address counters: load the bases on start, step on beat.
module pe_addr_gen #(
    parameter int ADDR_W = pe_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              inc_i,
    input  logic [ADDR_W-1:0] nbase_i,
    input  logic [ADDR_W-1:0] wbase_i,
    output logic [ADDR_W-1:0] naddr_o,
    output logic [ADDR_W-1:0] waddr_o
);
    localparam logic [ADDR_W-1:0] ONE_A = 1;

    logic [ADDR_W-1:0] naddr_q, waddr_q;

    // Addresses run on across instructions and wrap naturally at 2^ADDR_W
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            naddr_q <= '0;
            waddr_q <= '0;
        end else if (load_i) begin
            naddr_q <= nbase_i;
            waddr_q <= wbase_i;
        end else if (inc_i) begin
            naddr_q <= naddr_q + ONE_A;
            waddr_q <= waddr_q + ONE_A;
        end
    end

    assign naddr_o = naddr_q;
    assign waddr_o = waddr_q;

endmodule

// File: rtl/pe_seq_ctrl.sv
// Sequencer for the parallel_pe datapath: walks the instruction list, issues
// one SRAM read per beat (pe_vld/pe_ctl follow one cycle later, aligned with
// the read data) and collects PE results. Build option PE_SEQ_STALL_EN adds
// a stall input that suppresses beats while in RUN.
module pe_seq_ctrl #(
    parameter int ADDR_W  = pe_pkg::ADDR_W,
    parameter int INST_AW = 2,
    parameter int ITER_W  = pe_pkg::ITER_W,
    parameter int RES_W   = pe_pkg::RES_W
) (
    input  logic          clk,
    input  logic          rst_n,
    pe_seq_ctrl_if.master bus
);
    import pe_pkg::*;

    localparam logic [INST_AW:0]  ONE_I = 1;
    localparam logic [ITER_W-1:0] ONE_B = 1;

    state_e            state_q;
    logic [INST_AW:0]  num_q, idx_q, exp_q, res_cnt_q;
    logic [ITER_W-1:0] len_q, beat_q;
    logic              pe_vld_q, done_q;
    logic [1:0]        pe_ctl_q;
    logic              stall, busy, accept, fire, last_beat, last_inst;
    logic [RES_W-1:0]  res_data;

`ifdef PE_SEQ_STALL_EN
    assign stall = bus.stall;
`else
    assign stall = 1'b0;
`endif

    assign busy      = (state_q != IDLE);
    assign accept    = (state_q == IDLE) && bus.start;
    assign fire      = (state_q == RUN) && !stall;
    assign last_beat = (beat_q == len_q - ONE_B);
    assign last_inst = (idx_q == num_q - ONE_I);

    // Run state machine; pe_vld/pe_ctl registered so they line up with read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            num_q     <= '0;
            idx_q     <= '0;
            exp_q     <= '0;
            res_cnt_q <= '0;
            len_q     <= '0;
            beat_q    <= '0;
            pe_vld_q  <= 1'b0;
            pe_ctl_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            pe_vld_q <= fire;
            pe_ctl_q <= '0;
            if (bus.pe_res_vld && busy) res_cnt_q <= res_cnt_q + ONE_I;
            case (state_q)
                IDLE: if (bus.start) begin
                    num_q     <= bus.cfg_num_inst;
                    idx_q     <= '0;
                    exp_q     <= '0;
                    res_cnt_q <= '0;
                    state_q   <= (bus.cfg_num_inst == '0) ? DONE : FETCH;
                end
                FETCH: begin
                    len_q  <= bus.inst_data;
                    beat_q <= '0;
                    if (bus.inst_data == '0) begin
                        // Empty instruction: no beats, no result expected
                        if (last_inst) state_q <= DRAIN;
                        else           idx_q   <= idx_q + ONE_I;
                    end else begin
                        exp_q   <= exp_q + ONE_I;
                        state_q <= RUN;
                    end
                end
                RUN: if (fire) begin
                    pe_ctl_q[CTL_FIRST] <= (beat_q == '0);
                    pe_ctl_q[CTL_LAST]  <= last_beat;
                    beat_q              <= beat_q + ONE_B;
                    if (last_beat) begin
                        if (last_inst) begin
                            state_q <= DRAIN;
                        end else begin
                            idx_q   <= idx_q + ONE_I;
                            state_q <= FETCH;
                        end
                    end
                end
                DRAIN: if (res_cnt_q == exp_q) state_q <= DONE;
                DONE: begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    pe_addr_gen #(.ADDR_W(ADDR_W)) u_addr (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (accept),
        .inc_i   (fire),
        .nbase_i (bus.cfg_neuron_base),
        .wbase_i (bus.cfg_weight_base),
        .naddr_o (bus.neuron_addr),
        .waddr_o (bus.weight_addr)
    );

    // Results are only accepted while a run is in flight
    assign res_data        = bus.pe_result;
    assign bus.res_wr_en   = bus.pe_res_vld && busy;
    assign bus.res_wr_addr = res_cnt_q[INST_AW-1:0];
    assign bus.res_wr_data = bus.res_wr_en ? res_data : '0;

    assign bus.busy      = busy;
    assign bus.done      = done_q;
    assign bus.inst_addr = idx_q[INST_AW-1:0];
    assign bus.mem_rd_en = fire;
    assign bus.pe_vld    = pe_vld_q;
    assign bus.pe_ctl    = pe_ctl_q;

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Directed bench for pe_seq_ctrl: table of instruction lists with expected
// beat/result counts, a fixed-latency PE model, plus hand-written sequences
// for restart, reset abort and (with PE_SEQ_STALL_EN) stall.
module tb_pe_seq_ctrl;

    localparam int LAT = 3;

    typedef struct {
        logic [2:0]  num;
        logic [7:0]  len [4];
        logic [15:0] nb;
        logic [15:0] wb;
        int          exp_beats;
        int          exp_res;
    } vec_t;

    logic clk, rst_n;
    int   cyc = 0;
    int   checks = 0, failures = 0;

    pe_seq_ctrl_if bus ();

    pe_seq_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instruction memory, combinational read
    logic [7:0] imem [4];
    assign bus.inst_data = imem[bus.inst_addr];

    // PE model: result = 0xC0DE0000 + beats in the instruction, LAT-1 cycles after last beat
    logic        m_vld, inj_vld;
    logic [31:0] m_data;
    logic        pv [LAT];
    logic [31:0] pd [LAT];
    int          acc;
    assign bus.pe_res_vld = m_vld | inj_vld;
    assign bus.pe_result  = inj_vld ? 32'h1234_5678 : m_data;

    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) pv[i] = 1'b0;
            m_vld = 1'b0;
            acc   = 0;
        end else begin
            for (int i = LAT - 1; i > 0; i--) begin
                pv[i] = pv[i-1];
                pd[i] = pd[i-1];
            end
            pv[0] = 1'b0;
            if (bus.pe_vld) begin
                acc = bus.pe_ctl[0] ? 1 : acc + 1;
                if (bus.pe_ctl[1]) begin
                    pv[0] = 1'b1;
                    pd[0] = 32'hC0DE_0000 + 32'(acc);
                end
            end
            m_vld  = pv[LAT-1];
            m_data = pd[LAT-1];
        end
    end

    // Monitor, sampled mid-cycle
    logic [15:0] q_na[$], q_wa[$];
    logic [1:0]  q_ctl[$];
    int          q_vc[$];
    logic [1:0]  q_ra[$];
    logic [31:0] q_rd[$];
    int          done_cnt = 0, done_cyc = 0, start_cyc = 0;

    always @(negedge clk) begin
        if (bus.mem_rd_en) begin
            q_na.push_back(bus.neuron_addr);
            q_wa.push_back(bus.weight_addr);
        end
        if (bus.pe_vld) begin
            q_ctl.push_back(bus.pe_ctl);
            q_vc.push_back(cyc);
        end
        if (bus.res_wr_en) begin
            q_ra.push_back(bus.res_wr_addr);
            q_rd.push_back(bus.res_wr_data);
        end
        if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic set_stall(input logic s);
`ifdef PE_SEQ_STALL_EN
        bus.stall = s;
`else
        if (s) $display("note: stall requested without stall support");
`endif
    endtask

    // Called at posedge+1; start is high for exactly one cycle
    task automatic launch(input vec_t v);
        q_na.delete(); q_wa.delete(); q_ctl.delete(); q_vc.delete();
        q_ra.delete(); q_rd.delete();
        done_cnt = 0;
        for (int j = 0; j < 4; j++) imem[j] = v.len[j];
        bus.cfg_num_inst    = v.num;
        bus.cfg_neuron_base = v.nb;
        bus.cfg_weight_base = v.wb;
        bus.start           = 1'b1;
        start_cyc           = cyc;
        @(posedge clk); #1;
        bus.start           = 1'b0;
        // Scramble config to show it was latched
        bus.cfg_num_inst    = 3'd1;
        bus.cfg_neuron_base = 16'hDEAD;
        bus.cfg_weight_base = 16'hBEEF;
    endtask

    task automatic run_vec(input vec_t v, input int restart_at, input int stall_at);
        int t;
        launch(v);
        t = 1;
        while (done_cnt == 0 && t < 3000) begin
            bus.start = (t == restart_at);
            set_stall(stall_at > 0 && t >= stall_at && t < stall_at + 3);
            @(posedge clk); #1;
            t++;
        end
        bus.start = 1'b0;
        set_stall(1'b0);
        chk("done_seen", int'(done_cnt > 0), 1);
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic check_vec(input string nm, input vec_t v, input bit stalled);
        int         cur, ea, ec, et, er, n;
        bit         started;
        logic [1:0] ectl[$];
        int         eoff[$];
        logic [31:0] erd[$];
        logic [15:0] exa;
        cur = 0; started = 0;
        for (int j = 0; j < int'(v.num); j++) begin
            if (started) cur++;
            if (v.len[j] != 0) begin
                started = 1;
                erd.push_back(32'hC0DE_0000 + 32'(v.len[j]));
                for (int b = 0; b < int'(v.len[j]); b++) begin
                    ectl.push_back({b == int'(v.len[j]) - 1, b == 0});
                    eoff.push_back(cur);
                    cur++;
                end
            end
        end
        chk({nm, "_beats"}, q_ctl.size(), v.exp_beats);
        chk({nm, "_reads"}, q_na.size(), v.exp_beats);
        ea = 0; ec = 0; et = 0; er = 0;
        n = (q_na.size() < ectl.size()) ? q_na.size() : ectl.size();
        for (int i = 0; i < n; i++) begin
            exa = 16'(v.nb + 16'(i));
            if (q_na[i] !== exa) ea++;
            exa = 16'(v.wb + 16'(i));
            if (q_wa[i] !== exa) ea++;
        end
        n = (q_ctl.size() < ectl.size()) ? q_ctl.size() : ectl.size();
        for (int i = 0; i < n; i++) begin
            if (q_ctl[i] !== ectl[i]) ec++;
            if (!stalled && (q_vc[i] - q_vc[0]) != eoff[i]) et++;
        end
        chk({nm, "_addr_errs"}, ea, 0);
        chk({nm, "_ctl_errs"}, ec, 0);
        if (!stalled) chk({nm, "_timing_errs"}, et, 0);
        else if (n > 0) chk({nm, "_span"}, q_vc[n-1] - q_vc[0], eoff[n-1] + 3);
        chk({nm, "_results"}, q_rd.size(), v.exp_res);
        n = (q_rd.size() < erd.size()) ? q_rd.size() : erd.size();
        for (int i = 0; i < n; i++) begin
            if (q_rd[i] !== erd[i]) er++;
            if (int'(q_ra[i]) != i) er++;
        end
        chk({nm, "_res_errs"}, er, 0);
        chk({nm, "_done_cnt"}, done_cnt, 1);
        chk({nm, "_busy_end"}, int'(bus.busy), 0);
        if (v.num == 0) chk({nm, "_done_lat"}, done_cyc - start_cyc, 2);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_busy"},  int'(bus.busy), 0);
        chk({nm, "_done"},  int'(bus.done), 0);
        chk({nm, "_rd_en"}, int'(bus.mem_rd_en), 0);
        chk({nm, "_vld"},   int'(bus.pe_vld), 0);
        chk({nm, "_ctl"},   int'(bus.pe_ctl), 0);
        chk({nm, "_naddr"}, int'(bus.neuron_addr), 0);
        chk({nm, "_waddr"}, int'(bus.weight_addr), 0);
        chk({nm, "_iaddr"}, int'(bus.inst_addr), 0);
        chk({nm, "_wr_en"}, int'(bus.res_wr_en), 0);
    endtask

    vec_t vecs [6];

    initial begin
        vecs[0] = '{3'd4, '{8'd32, 8'd32, 8'd36, 8'd40}, 16'h0000, 16'h0000, 140, 4};
        vecs[1] = '{3'd4, '{8'd1,  8'd0,  8'd3,  8'd1 }, 16'h0020, 16'h0100, 5,   3};
        vecs[2] = '{3'd0, '{8'd5,  8'd5,  8'd5,  8'd5 }, 16'h0010, 16'h0010, 0,   0};
        vecs[3] = '{3'd1, '{8'd4,  8'd9,  8'd9,  8'd9 }, 16'hFFFE, 16'h7FFE, 4,   1};
        vecs[4] = '{3'd2, '{8'd0,  8'd0,  8'd7,  8'd7 }, 16'h0040, 16'h0080, 0,   0};
        vecs[5] = '{3'd3, '{8'd2,  8'd5,  8'd1,  8'd0 }, 16'h0300, 16'h0400, 8,   3};

        rst_n = 1'b0;
        inj_vld = 1'b0;
        bus.start = 1'b0;
        bus.cfg_num_inst = '0;
        bus.cfg_neuron_base = '0;
        bus.cfg_weight_base = '0;
        set_stall(1'b0);
        for (int j = 0; j < 4; j++) imem[j] = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Result strobe while idle must not be written
        inj_vld = 1'b1;
        @(negedge clk);
        chk("idle_res_ignored", int'(bus.res_wr_en), 0);
        @(posedge clk); #1;
        inj_vld = 1'b0;

        for (int k = 0; k < 6; k++) begin
            run_vec(vecs[k], 0, 0);
            check_vec($sformatf("vec%0d", k), vecs[k], 1'b0);
        end

        // Hand marks from the reference lists
        run_vec(vecs[1], 0, 0);
        chk("len1_ctl11", (q_ctl.size() > 0) ? int'(q_ctl[0]) : -1, 3);
        run_vec(vecs[3], 0, 0);
        chk("wrap_addr2", (q_na.size() > 2) ? int'(q_na[2]) : -1, 0);

        // Second start mid-run is ignored
        run_vec(vecs[0], 50, 0);
        check_vec("restart", vecs[0], 1'b0);

        // Reset in RUN aborts without a done pulse
        launch(vecs[0]);
        repeat (20) @(posedge clk);
        #1;
        chk("pre_abort_busy", int'(bus.busy), 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk_all_zero("abort");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt, 0);
        chk("abort_vld_idle", int'(bus.pe_vld), 0);
        run_vec(vecs[0], 0, 0);
        check_vec("post_abort", vecs[0], 1'b0);

`ifdef PE_SEQ_STALL_EN
        // Three stall cycles inside the first instruction
        run_vec(vecs[0], 0, 12);
        check_vec("stall", vecs[0], 1'b1);
        chk("stall_gap", (q_vc.size() > 10) ? q_vc[10] - q_vc[9] : -1, 4);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
